// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares one memory port between instruction fetch and load/store,
// one transaction in flight, data priority with a fetch starvation guard.
module rv32i_mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            clear_i,
  input  logic            f_req_i,
  input  logic [XLEN-1:0] f_addr_i,
  output logic            f_gnt_o,
  output logic            f_rvalid_o,
  output logic [XLEN-1:0] f_rdata_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [3:0]      d_be_i,
  input  logic [XLEN-1:0] d_addr_i,
  input  logic [XLEN-1:0] d_wdata_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            busy_o
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, WAIT_F, WAIT_D} state_t;
  state_t     state;
  logic       locked, lock_f, drop;
  logic [3:0] starve;
  logic       arb, hold, sel_f, sel_d, gnt_f, gnt_d;
  assign arb  = state == IDLE || mem_rvalid_i;
  // a flush withdraws a stalled fetch, so its lock no longer binds
  assign hold = locked && !(lock_f && clear_i);
  assign sel_f = reset_ni && arb && (hold ? lock_f : f_req_i && (!d_req_i || starve == LIM));
  assign sel_d = reset_ni && arb && (hold ? !lock_f : d_req_i && !(f_req_i && starve == LIM));
  assign gnt_f = mem_gnt_i && sel_f;
  assign gnt_d = mem_gnt_i && sel_d;
  assign f_gnt_o     = gnt_f;
  assign d_gnt_o     = gnt_d;
  assign mem_req_o   = sel_f || sel_d;
  assign mem_we_o    = sel_d && d_we_i;
  assign mem_be_o    = sel_f ? 4'hF : sel_d ? d_be_i : 4'h0;
  assign mem_addr_o  = sel_f ? f_addr_i : sel_d ? d_addr_i : '0;
  assign mem_wdata_o = sel_d ? d_wdata_i : '0;
  assign f_rvalid_o  = reset_ni && state == WAIT_F && mem_rvalid_i && !drop && !clear_i;
  assign d_rvalid_o  = reset_ni && state == WAIT_D && mem_rvalid_i;
  assign f_rdata_o   = reset_ni ? mem_rdata_i : '0;
  assign d_rdata_o   = reset_ni ? mem_rdata_i : '0;
  assign busy_o      = state != IDLE;
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state  <= IDLE;
      locked <= 1'b0;
      lock_f <= 1'b0;
      starve <= '0;
      drop   <= 1'b0;
    end else begin
      if (arb) begin
        state  <= gnt_f ? WAIT_F : gnt_d ? WAIT_D : IDLE;
        locked <= (sel_f || sel_d) && !mem_gnt_i;
        lock_f <= sel_f;
      end
      if (gnt_f)
        starve <= '0;
      else if (gnt_d)
        starve <= !f_req_i ? '0 : starve == LIM ? LIM : starve + 4'd1;
      // a flush during WAIT_F marks the in-flight response as stale
      if (clear_i && (gnt_f || (state == WAIT_F && !mem_rvalid_i)))
        drop <= 1'b1;
      else if (state == WAIT_F && mem_rvalid_i)
        drop <= 1'b0;
    end
  end
endmodule
